cdb_arbiter: RTL and testbench



---
 rtl/tomasulo_pkg.sv | 12 +
 rtl/cdb_rr_picker.sv | 34 +++
 rtl/cdb_arbiter.sv | 104 ++++++++++
 tb/tb_cdb_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Tomasulo-core shared constants: tag/value widths, the reserved "no producer" tag,
// and the CDB transmit FSM encodings.
package tomasulo_pkg;

    localparam int unsigned     TAG_W       = 5;
    localparam int unsigned     DATA_W      = 32;
    localparam logic [TAG_W-1:0] INVALID_TAG = 5'b11111;

    localparam logic [0:0] CDB_ST_IDLE  = 1'b0;
    localparam logic [0:0] CDB_ST_BCAST = 1'b1;

endpackage

// File: rtl/cdb_rr_picker.sv
// Combinational round-robin select: first set bit of i_full scanning upward
// from i_rr_ptr with wrap-around.
module cdb_rr_picker #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] i_full,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [NUM_SRC-1:0] o_sel,
    output logic [IDX_W-1:0]   o_sel_idx,
    output logic               o_any
);

    logic [31:0] w_cand;

    always_comb begin
        o_sel     = '0;
        o_sel_idx = '0;
        o_any     = 1'b0;
        w_cand    = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            w_cand = 32'(i_rr_ptr) + k;
            if (w_cand >= NUM_SRC) begin
                w_cand = w_cand - NUM_SRC;
            end
            if (!o_any && i_full[w_cand[IDX_W-1:0]]) begin
                o_any     = 1'b1;
                o_sel_idx = w_cand[IDX_W-1:0];
            end
        end
        o_sel[o_sel_idx] = o_any;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit side: one holding buffer per functional unit, round-robin
// arbitration, and a strobe that always has a low gap cycle after it.
module cdb_arbiter #(
    parameter int unsigned       NUM_SRC     = 4,
    parameter int unsigned       TAG_W       = tomasulo_pkg::TAG_W,
    parameter int unsigned       DATA_W      = tomasulo_pkg::DATA_W,
    parameter logic [TAG_W-1:0]  INVALID_TAG = tomasulo_pkg::INVALID_TAG
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        in_req_valid,
    output logic [NUM_SRC-1:0]        out_req_ready,
    input  logic [NUM_SRC*TAG_W-1:0]  in_req_tag,
    input  logic [NUM_SRC*DATA_W-1:0] in_req_val,
    output logic                      out_CDB_broadcast,
    output logic [TAG_W-1:0]          out_CDB_tag,
    output logic [DATA_W-1:0]         out_CDB_val,
    output logic [NUM_SRC-1:0]        out_grant
);

    localparam int unsigned      IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

    logic [0:0]         r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [NUM_SRC-1:0] r_full;
    logic [TAG_W-1:0]   r_tag [NUM_SRC];
    logic [DATA_W-1:0]  r_val [NUM_SRC];
    logic [TAG_W-1:0]   r_cdb_tag;
    logic [DATA_W-1:0]  r_cdb_val;
    logic [NUM_SRC-1:0] r_grant;

    logic [NUM_SRC-1:0] w_sel;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_any;
    logic               w_launch;
    logic [NUM_SRC-1:0] w_release;
    logic [NUM_SRC-1:0] w_accept;
    logic [TAG_W-1:0]   w_in_tag [NUM_SRC];
    logic [DATA_W-1:0]  w_in_val [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign w_in_tag[g] = in_req_tag[g*TAG_W +: TAG_W];
        assign w_in_val[g] = in_req_val[g*DATA_W +: DATA_W];
    end

    cdb_rr_picker #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_full    (r_full),
        .i_rr_ptr  (r_rr_ptr),
        .o_sel     (w_sel),
        .o_sel_idx (w_sel_idx),
        .o_any     (w_any)
    );

    // A buffer being drained this cycle may be refilled at the same edge.
    assign w_launch      = (r_state == tomasulo_pkg::CDB_ST_IDLE) && w_any;
    assign w_release     = w_launch ? w_sel : '0;
    assign out_req_ready = ~r_full | w_release;
    assign w_accept      = in_req_valid & out_req_ready;

    assign out_CDB_broadcast = (r_state == tomasulo_pkg::CDB_ST_BCAST);
    assign out_CDB_tag       = r_cdb_tag;
    assign out_CDB_val       = r_cdb_val;
    assign out_grant         = r_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= tomasulo_pkg::CDB_ST_IDLE;
            r_rr_ptr  <= '0;
            r_full    <= '0;
            r_cdb_tag <= INVALID_TAG;
            r_cdb_val <= '0;
            r_grant   <= '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                r_tag[i] <= INVALID_TAG;
                r_val[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (w_accept[i]) begin
                    r_full[i] <= (w_in_tag[i] != INVALID_TAG);
                    r_tag[i]  <= w_in_tag[i];
                    r_val[i]  <= w_in_val[i];
                end else if (w_release[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
            if (r_state == tomasulo_pkg::CDB_ST_BCAST) begin
                r_state <= tomasulo_pkg::CDB_ST_IDLE;
                r_grant <= '0;
            end else if (w_any) begin
                r_state   <= tomasulo_pkg::CDB_ST_BCAST;
                r_grant   <= w_sel;
                r_cdb_tag <= r_tag[w_sel_idx];
                r_cdb_val <= r_val[w_sel_idx];
                r_rr_ptr  <= (w_sel_idx == LAST_IDX) ? '0 : w_sel_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations plus a
// random soak, all cross-checked every cycle against a behavioural model and scoreboard.
module tb_cdb_arbiter;

    localparam int          N   = 4;
    localparam int          TW  = 5;
    localparam int          DW  = 32;
    localparam logic [4:0]  INV = 5'h1F;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_req_valid;
    logic [N-1:0]    out_req_ready;
    logic [N*TW-1:0] in_req_tag;
    logic [N*DW-1:0] in_req_val;
    logic            out_CDB_broadcast;
    logic [TW-1:0]   out_CDB_tag;
    logic [DW-1:0]   out_CDB_val;
    logic [N-1:0]    out_grant;

    cdb_arbiter #(
        .NUM_SRC     (N),
        .TAG_W       (TW),
        .DATA_W      (DW),
        .INVALID_TAG (INV)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_req_valid      (in_req_valid),
        .out_req_ready     (out_req_ready),
        .in_req_tag        (in_req_tag),
        .in_req_val        (in_req_val),
        .out_CDB_broadcast (out_CDB_broadcast),
        .out_CDB_tag       (out_CDB_tag),
        .out_CDB_val       (out_CDB_val),
        .out_grant         (out_grant)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_acc  = 0;
    int n_bc   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard of accepted results, keyed by source, in acceptance order.
    typedef struct {
        int         src;
        logic [4:0] tag;
        logic [31:0] val;
        int         t;
    } ent_t;
    ent_t sb[$];

    // Behavioural model: buffers, pointer, and what the bus shows this cycle.
    int          m_ptr;
    bit          m_strobe;
    int          m_gsrc;
    logic [4:0]  m_ltag;
    logic [31:0] m_lval;
    bit          m_full [N];
    logic [4:0]  m_tag  [N];
    logic [31:0] m_val  [N];
    bit          prev_strobe;

    always @(negedge clk) begin : mdl
        int          sel;
        int          s;
        int          gi;
        int          hit;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_grant;
        cyc++;
        if (rst) begin
            m_ptr = 0; m_strobe = 0; m_gsrc = 0; m_ltag = INV; m_lval = '0;
            for (int i = 0; i < N; i++) m_full[i] = 0;
            sb.delete();
            prev_strobe = 0;
            chk("rst_hold_strobe", out_CDB_broadcast, 0);
            chk("rst_hold_tag", out_CDB_tag, INV);
            chk("rst_hold_grant", out_grant, 0);
        end else begin
            exp_grant = '0;
            if (m_strobe) exp_grant[m_gsrc] = 1'b1;
            chk("mdl_strobe", out_CDB_broadcast, m_strobe);
            chk("mdl_grant", out_grant, exp_grant);
            chk("mdl_tag", out_CDB_tag, m_ltag);
            chk("mdl_val", out_CDB_val, m_lval);

            sel = -1;
            if (!m_strobe) begin
                for (int k = 0; k < N; k++) begin
                    s = (m_ptr + k) % N;
                    if (sel < 0 && m_full[s]) sel = s;
                end
            end
            for (int i = 0; i < N; i++) exp_rdy[i] = !m_full[i] || (sel == i);
            chk("mdl_ready", out_req_ready, exp_rdy);
            chk("strobe_gap", logic'(prev_strobe && out_CDB_broadcast), 0);

            if (out_CDB_broadcast) begin
                n_bc++;
                chk("grant_onehot", logic'($onehot(out_grant)), 1);
                gi = 0;
                for (int i = 0; i < N; i++) if (out_grant[i]) gi = i;
                hit = -1;
                for (int q = 0; q < sb.size(); q++) if (hit < 0 && sb[q].src == gi) hit = q;
                if (hit < 0) begin
                    chk("sb_unexpected_bcast", 1, 0);
                end else begin
                    chk("sb_tag", out_CDB_tag, sb[hit].tag);
                    chk("sb_val", out_CDB_val, sb[hit].val);
                    chk("sb_wait_le_2N", logic'((cyc - sb[hit].t - 1) <= 2 * N), 1);
                    sb.delete(hit);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (in_req_valid[i] && out_req_ready[i] && in_req_tag[i*TW +: TW] != INV) begin
                    sb.push_back('{i, in_req_tag[i*TW +: TW], in_req_val[i*DW +: DW], cyc});
                    n_acc++;
                end
            end

            if (sel >= 0) begin
                m_strobe = 1; m_gsrc = sel; m_ltag = m_tag[sel]; m_lval = m_val[sel];
                m_full[sel] = 0;
                m_ptr = (sel + 1) % N;
            end else begin
                m_strobe = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (in_req_valid[i] && exp_rdy[i]) begin
                    if (in_req_tag[i*TW +: TW] == INV) begin
                        m_full[i] = 0;
                    end else begin
                        m_full[i] = 1;
                        m_tag[i]  = in_req_tag[i*TW +: TW];
                        m_val[i]  = in_req_val[i*DW +: DW];
                    end
                end
            end
            prev_strobe = out_CDB_broadcast;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [4:0] t, input logic [31:0] d);
        in_req_valid[i]       = v;
        in_req_tag[i*TW +: TW] = t;
        in_req_val[i*DW +: DW] = d;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) drive(i, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        bit er [8];
        bit es [8];
        int idx;
        int k;
        logic acc;
        er = '{1, 1, 0, 1, 0, 1, 1, 1};
        es = '{0, 0, 1, 0, 1, 0, 1, 0};

        rst = 1'b1;
        in_req_valid = '0; in_req_tag = '0; in_req_val = '0;
        repeat (2) step();
        chk("rst_strobe", out_CDB_broadcast, 0);
        chk("rst_tag", out_CDB_tag, 5'h1F);
        chk("rst_val", out_CDB_val, 0);
        chk("rst_grant", out_grant, 0);
        rst = 1'b0;
        #1;
        chk("rst_ready", out_req_ready, 4'hF);
        step();

        // All four sources at once, then refill: order src0..src3 both times.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) drive(i, 1'b1, 5'(i + 1 + 4 * r), 32'h100 + 32'(i));
            step();
            idle_all();
            for (int j = 0; j < 8; j++) begin
                step();
                chk("all4_strobe", out_CDB_broadcast, logic'(j % 2 == 0));
                if (j % 2 == 0) begin
                    chk("all4_tag", out_CDB_tag, 64'(j / 2 + 1 + 4 * r));
                    chk("all4_grant", out_grant, 64'(1 << (j / 2)));
                end
            end
        end

        // Single source, two edges of latency.
        step();
        drive(2, 1'b1, 5'd3, 32'hDEADBEEF);
        step();
        idle_all();
        chk("single_gap", out_CDB_broadcast, 0);
        step();
        chk("single_strobe", out_CDB_broadcast, 1);
        chk("single_tag", out_CDB_tag, 5'd3);
        chk("single_val", out_CDB_val, 32'hDEADBEEF);
        chk("single_grant", out_grant, 4'b0100);
        step();
        chk("single_after", out_CDB_broadcast, 0);
        chk("single_after_grant", out_grant, 0);
        chk("single_tag_hold", out_CDB_tag, 5'd3);

        // Invalid tag is accepted and dropped.
        step();
        drive(1, 1'b1, 5'h1F, 32'h55);
        chk("inv_ready", out_req_ready[1], 1);
        step();
        idle_all();
        chk("inv_empty", out_req_ready, 4'hF);
        for (int j = 0; j < 4; j++) begin
            chk("inv_no_strobe", out_CDB_broadcast, 0);
            step();
        end
        chk("inv_tag_hold", out_CDB_tag, 5'd3);

        // Backpressure with refill in the release cycle.
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            if (idx < 3) drive(0, 1'b1, 5'(10 + idx), 32'hA0 + 32'(idx));
            else         drive(0, 1'b0, 5'd0, 32'd0);
            chk("bp_ready", out_req_ready[0], er[c]);
            chk("bp_strobe", out_CDB_broadcast, es[c]);
            if (es[c]) chk("bp_tag", out_CDB_tag, 64'(9 + c / 2));
            acc = in_req_valid[0] & out_req_ready[0];
            step();
            if (acc) idx++;
        end
        chk("bp_accepted", idx, 3);
        idle_all();
        step();

        // Reset in the middle of a broadcast.
        drive(3, 1'b1, 5'd7, 32'd77);
        drive(1, 1'b1, 5'd9, 32'd99);
        step();
        idle_all();
        k = 0;
        while (!out_CDB_broadcast && k < 10) begin
            step();
            k++;
        end
        chk("rstmid_reach_bcast", out_CDB_broadcast, 1);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_strobe", out_CDB_broadcast, 0);
        chk("rstmid_tag", out_CDB_tag, 5'h1F);
        chk("rstmid_val", out_CDB_val, 0);
        chk("rstmid_grant", out_grant, 0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rstmid_ready", out_req_ready, 4'hF);
        for (int j = 0; j < 6; j++) begin
            step();
            chk("rstmid_no_stale", out_CDB_broadcast, 0);
        end

        // Random soak.
        n_acc = 0;
        n_bc  = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++)
                drive(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            step();
        end
        idle_all();
        repeat (2 * N + 4) step();
        chk("soak_all_broadcast", n_bc, n_acc);
        chk("soak_sb_empty", sb.size(), 0);
        chk("soak_ready", out_req_ready, 4'hF);
        chk("soak_some_traffic", logic'(n_acc > 1000), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
